fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the F/D pipeline register.
- Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Presents pc/instruction pairs to the F/D register's pc_in/instruction_in.
- Absorbs decode stalls with a one-entry hold buffer; takes branch/jump redirects from execute, inserting one bubble per redirect.

Parameters:
- RESET_PC, 32'd0: PC loaded on reset.
- IMEM_AW, 12: instruction memory address width; imem_addr = pc_fetch[IMEM_AW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  F/D register not accepting; F/D we is driven by ~stall.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  32  target PC, valid when redirect=1.
- imem_addr  out  IMEM_AW  instruction memory address, combinational from pc_fetch.
- imem_q  in  32  instruction memory data for the address presented in the previous cycle.
- pc_out  out  32  PC of the instruction on instruction_out (word address).
- instruction_out  out  32  fetched instruction; 32'd0 (NOP) when not valid.
- valid_out  out  1  pc_out/instruction_out hold a real instruction.

Behaviour:
- Internal state:
  - pc_fetch[31:0]: address being presented.
  - pc_issued[31:0] with issued_valid: address whose data is on imem_q this cycle.
  - hold_valid, hold_instr[31:0], hold_pc[31:0].
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc_fetch=RESET_PC; pc_issued=0; issued_valid=0; hold_valid=0; hold_instr=0; hold_pc=0.
  - Outputs therefore read valid_out=0, instruction_out=0, pc_out=0, imem_addr=RESET_PC[IMEM_AW-1:0].
- Outputs (combinational mux, no added latency):
  - hold_valid=1: hold_pc / hold_instr, valid_out=1.
  - else issued_valid=1: pc_issued / imem_q, valid_out=1.
  - else: 0 / 0, valid_out=0.
- Derived modes:
  - BUBBLE: issued_valid=0 and hold_valid=0.
  - STREAM: issued_valid=1 and hold_valid=0.
  - HELD: hold_valid=1.
- Per-edge update, priority redirect > stall > advance:
  - redirect=1:
    - pc_fetch<=redirect_pc; issued_valid<=0; hold_valid<=0.
    - The next cycle is a bubble; any in-flight or held instruction is discarded.
    - stall is ignored that cycle.
  - stall=1, redirect=0:
    - pc_fetch holds.
    - If hold_valid=0 and issued_valid=1: hold_valid<=1, hold_instr<=imem_q, hold_pc<=pc_issued.
    - pc_issued<=pc_fetch; issued_valid<=1 (same address re-presented each stall cycle).
  - advance (stall=0, redirect=0):
    - hold_valid<=0 (held entry consumed this cycle).
    - pc_issued<=pc_fetch; issued_valid<=1; pc_fetch<=pc_fetch+1.
- Latency: an address presented in cycle N appears on instruction_out in cycle N+1, unless held or flushed.
- The first valid instruction after reset release appears one cycle after the first clock edge.
- Stall during BUBBLE: nothing is captured; the next cycle is STREAM with the same pc_fetch.
- Multi-cycle stall: hold is captured only on the first stall cycle and stays stable for the whole stall.
- Wrap-around:
  - pc_fetch+1 is modulo 2^32.
  - imem_addr wraps modulo 2^IMEM_AW via truncation; pc_out carries the full 32 bits.
- No instruction may be duplicated or skipped across any stall/advance sequence without redirect.

Test Plan:
- Memory model: imem_q(k)=32'h1000_0000+k.
- Reset release, no stall for 4 cycles -> edge0 output bubble (valid 0, instruction 0); then pc_out 0,1,2 with instruction 0x10000000, 0x10000001, 0x10000002; imem_addr 0,1,2,3.
- Streaming at pc_out=5, stall for 3 cycles -> pc_out=5, instruction 0x10000005 held all 3 cycles with valid_out=1; pc_fetch frozen at 6. After release -> pc 5 once more, then 6, 7 (no skip, no duplicate beyond the stalled slot).
- redirect=1 with redirect_pc=0x40 while streaming -> next cycle valid_out=0; following cycle pc_out=0x40, instruction 0x10000040.
- redirect=1 and stall=1 in the same cycle while HELD at pc 9 -> hold discarded; bubble next cycle; then pc_out 0x40 (redirect wins).
- pc_fetch redirected to 0xFFF (IMEM_AW=12), run 2 cycles -> pc_out 0xFFF then 0x1000; imem_addr 0xFFF then 0x000.
- Assert reset asynchronously mid-stall (between edges) -> all outputs 0 immediately, imem_addr=0; after release, sequence restarts at pc 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Brief    : Fetch-stage bus: control in, imem port, F/D register payload out.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int IMEM_AW = 12
);
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic [31:0]        pc_out;
  logic [31:0]        instruction_out;
  logic               valid_out;

  // master = fetch stage, slave = surrounding pipeline and instruction memory
  modport master (
    input  stall, redirect, redirect_pc, imem_q,
    output imem_addr, pc_out, instruction_out, valid_out
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_q,
    input  imem_addr, pc_out, instruction_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : PC owner and instruction fetch with one-entry stall hold buffer
//             and single-bubble branch/jump redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fetch_stage_if.master  bus
);

  logic [31:0] r_pcFetch;
  logic [31:0] r_pcIssued;
  logic        r_issuedValid;
  logic        r_holdValid;
  logic [31:0] r_holdInstr;
  logic [31:0] r_holdPc;

  logic [31:0] w_pcOut;
  logic [31:0] w_instrOut;
  logic        w_validOut;

  // Redirect beats stall beats advance; a redirect flushes both in-flight and held work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcFetch     <= RESET_PC;
      r_pcIssued    <= 32'd0;
      r_issuedValid <= 1'b0;
      r_holdValid   <= 1'b0;
      r_holdInstr   <= 32'd0;
      r_holdPc      <= 32'd0;
    end else if (bus.redirect) begin
      r_pcFetch     <= bus.redirect_pc;
      r_issuedValid <= 1'b0;
      r_holdValid   <= 1'b0;
    end else if (bus.stall) begin
      // Capture only once per stall; the re-presented address keeps imem_q
      // pointing at the next instruction so nothing is lost on release.
      if (!r_holdValid && r_issuedValid) begin
        r_holdValid <= 1'b1;
        r_holdInstr <= bus.imem_q;
        r_holdPc    <= r_pcIssued;
      end
      r_pcIssued    <= r_pcFetch;
      r_issuedValid <= 1'b1;
    end else begin
      r_holdValid   <= 1'b0;
      r_pcIssued    <= r_pcFetch;
      r_issuedValid <= 1'b1;
      r_pcFetch     <= r_pcFetch + 32'd1;
    end
  end

  always_comb begin
    w_pcOut    = 32'd0;
    w_instrOut = 32'd0;
    w_validOut = 1'b0;
    if (r_holdValid) begin
      w_pcOut    = r_holdPc;
      w_instrOut = r_holdInstr;
      w_validOut = 1'b1;
    end else if (r_issuedValid) begin
      w_pcOut    = r_pcIssued;
      w_instrOut = bus.imem_q;
      w_validOut = 1'b1;
    end
  end

  assign bus.imem_addr       = r_pcFetch[IMEM_AW-1:0];
  assign bus.pc_out          = w_pcOut;
  assign bus.instruction_out = w_instrOut;
  assign bus.valid_out       = w_validOut;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed self-checking bench for fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam int C_AW = 12;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_stage_if #(.IMEM_AW(C_AW)) bus ();

  fetch_stage #(
    .RESET_PC (32'd0),
    .IMEM_AW  (C_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: q(k) = 0x1000_0000 + k, one-cycle latency.
  always @(posedge clk)
    bus.imem_q <= 32'h1000_0000 + {{(32-C_AW){1'b0}}, bus.imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic valid, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, valid});
    chk({tag, ".pc"},    bus.pc_out, pc);
    chk({tag, ".instr"}, bus.instruction_out, instr);
    chk({tag, ".addr"},  {{(32-C_AW){1'b0}}, bus.imem_addr}, addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.imem_q = 32'd0;

    repeat (2) step();
    chkOut("reset", 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    chkOut("edge0", 1'b0, 32'd0, 32'd0, 32'd0);

    // Straight-line streaming
    step(); chkOut("s0", 1'b1, 32'd0, 32'h1000_0000, 32'd1);
    step(); chkOut("s1", 1'b1, 32'd1, 32'h1000_0001, 32'd2);
    step(); chkOut("s2", 1'b1, 32'd2, 32'h1000_0002, 32'd3);
    step(); chkOut("s3", 1'b1, 32'd3, 32'h1000_0003, 32'd4);
    step(); chkOut("s4", 1'b1, 32'd4, 32'h1000_0004, 32'd5);
    step(); chkOut("s5", 1'b1, 32'd5, 32'h1000_0005, 32'd6);

    // Three-cycle stall at pc 5
    bus.stall = 1'b1;
    step(); chkOut("st1", 1'b1, 32'd5, 32'h1000_0005, 32'd6);
    step(); chkOut("st2", 1'b1, 32'd5, 32'h1000_0005, 32'd6);
    step();
    bus.stall = 1'b0;
    chkOut("rel5", 1'b1, 32'd5, 32'h1000_0005, 32'd6);
    step(); chkOut("rel6", 1'b1, 32'd6, 32'h1000_0006, 32'd7);
    step(); chkOut("rel7", 1'b1, 32'd7, 32'h1000_0007, 32'd8);

    // Redirect while streaming
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    chkOut("rd_bub", 1'b0, 32'd0, 32'd0, 32'h40);
    step(); chkOut("rd_40", 1'b1, 32'h40, 32'h1000_0040, 32'h41);

    // Reach HELD at pc 9, then redirect and stall together
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd9;
    step();
    bus.redirect = 1'b0;
    chkOut("to9_bub", 1'b0, 32'd0, 32'd0, 32'd9);
    step(); chkOut("s9", 1'b1, 32'd9, 32'h1000_0009, 32'd10);
    bus.stall = 1'b1;
    step(); chkOut("held9", 1'b1, 32'd9, 32'h1000_0009, 32'd10);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    chkOut("rs_bub", 1'b0, 32'd0, 32'd0, 32'h40);
    step(); chkOut("rs_40", 1'b1, 32'h40, 32'h1000_0040, 32'h41);

    // imem_addr wraps, pc_out keeps full width
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFF;
    step();
    bus.redirect = 1'b0;
    chkOut("w_bub", 1'b0, 32'd0, 32'd0, 32'hFFF);
    step(); chkOut("wFFF",  1'b1, 32'hFFF,  32'h1000_0FFF, 32'h000);
    step(); chkOut("w1000", 1'b1, 32'h1000, 32'h1000_0000, 32'h001);

    // Asynchronous reset in the middle of a stall
    bus.stall = 1'b1;
    step(); chkOut("pre_rst", 1'b1, 32'h1000, 32'h1000_0000, 32'h001);
    #2;
    reset = 1'b1;
    #1;
    chkOut("arst", 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    reset = 1'b0;
    bus.stall = 1'b0;
    #1;
    chkOut("post_rst", 1'b0, 32'd0, 32'd0, 32'd0);
    step(); chkOut("r0", 1'b1, 32'd0, 32'h1000_0000, 32'd1);
    step(); chkOut("r1", 1'b1, 32'd1, 32'h1000_0001, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
